alu_seg_scan: RTL and testbench
===============================

// Module: alu_seg_scan
// PURPOSE
//  Parametrised registered ALU with a multiplexed 7-segment display driver.
//  Captures two WIDTH-bit operands and an op code on a load strobe. Computes add, sub, parity or compare
//  in a fixed 1-cycle EXEC state, then holds the result.
//  Scans the result as hex digits across DIGITS common-anode displays; sits between board switches and display pins.
// PARAMETERS
//  WIDTH        3      operand width in bits (>=2); result is WIDTH+1 bits
//  DIGITS       2      display digits scanned; 4*DIGITS >= WIDTH+1 required
//  REFRESH_DIV  50000  clk cycles each digit stays lit (>=2)
// PORTS
//  clk           in   1            single clock, all logic on rising edge
//  rst           in   1            synchronous, active-high reset
//  in_a          in   WIDTH        operand A
//  in_b          in   WIDTH        operand B
//  sel           in   2            op: 00 add, 01 sub, 10 parity, 11 compare
//  load          in   1            capture strobe (sampled, level; one capture per accepted cycle)
//  busy          out  1            high during EXEC
//  result_valid  out  1            high while in SHOW
//  result        out  WIDTH+1      registered raw result
//  parity        out  1            registered XOR-reduce of {A,B}
//  an            out  DIGITS       anode enables, active-low, one-hot-low while SHOW
//  seg           out  7            segments {a,b,c,d,e,f,g}, active-low
//  dp            out  1            decimal point, active-low
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, result=0, parity=0, busy=0, result_valid=0,
//   an=all 1, seg=7'h7F, dp=1, prescaler=0, digit index=0. Reset wins over any other input.
//  FSM: IDLE --load--> EXEC --(always)--> SHOW --load--> EXEC.
//   Capture occurs on the edge where load=1 in IDLE/SHOW. It registers in_a, in_b and sel.
//   load in EXEC is ignored. No queue and no capture.
//   EXEC lasts exactly 1 cycle (busy=1). result, parity, result_valid update on the edge leaving EXEC.
//   Load-to-result_valid latency: 2 edges.
//  Arithmetic (captured operands, unsigned):
//   add: result = {carry, A+B}, full WIDTH+1 bits.
//   sub: result = A-B in WIDTH+1-bit two's complement; neg flag = result[WIDTH].
//   parity: result = {WIDTH{0}, ^{A,B}}.
//   compare: result = 1 if A>B, 2 if A==B, 4 if A<B (zero-extended/truncated to WIDTH+1).
//   parity output updates for every op.
//  Display value: sub with neg=1 shows magnitude (B-A) and lights dp on digit 0. Otherwise the raw result is shown, dp=1.
//   Nibble k of the zero-extended value appears on digit k (digit 0 = LSN).
//  Scan: in SHOW, prescaler counts 0..REFRESH_DIV-1, wraps.
//   On wrap, digit index increments mod DIGITS (DIGITS-1 -> 0).
//   an[idx]=0, others 1; seg/dp registered with an (same cycle change).
//   Leaving SHOW (to EXEC) holds prescaler/index. In IDLE/EXEC, an=all 1, seg=7'h7F, dp=1 (blank).
//  Hex font (abcdefg active-low): 0=0000001 1=1001111 2=0010010 3=0000110
//   4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100
//   A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
// CONFIGURATION
//  LEAD_ZERO_BLANK_EN defined:
//   any digit k>0 whose nibble and all higher nibbles are 0 outputs seg=7'h7F.
//   Its an stays asserted, and digit 0 is never blanked.
//  LEAD_ZERO_BLANK_EN undefined: every digit shows its nibble, leading zeros as '0'.
// TESTING (WIDTH=3, DIGITS=2, REFRESH_DIV=4, macro undefined unless noted)
//  1. rst high 2 cycles -> an=2'b11, seg=7'h7F, dp=1, busy=0, result_valid=0, result=0.
//  2. A=5,B=6,sel=00,load 1 cycle -> busy=1 next cycle; then result=4'hB, result_valid=1;
//     digit0 seg=1100000 ('b'), digit1 seg=0000001 ('0').
//  3. A=2,B=5,sel=01 -> result=4'b1101; digit0 seg=0000110 ('3') with dp=0.
//     Then A=7,B=7,sel=11 -> result=2, parity=0.
//  4. In SHOW: an sequence 10 for 4 cycles, 01 for 4, 10 ...; load held high during EXEC captures only once.
//     Then rst asserted mid-SHOW -> blank outputs next edge.
//  5. LEAD_ZERO_BLANK_EN, A=1,B=2,sel=00 -> digit0 '3', digit1 seg=7'h7F with an still scanning.

Source files
------------

// File: rtl/alu_seg_scan.sv
// rtl/alu_seg_scan.sv - registered ALU (add/sub/parity/compare) with multiplexed hex 7-segment scan.
// Optional LEAD_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module alu_seg_scan #(
    parameter int WIDTH       = 3,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [1:0]        sel,
    input  logic              load,
    output logic              busy,
    output logic              result_valid,
    output logic [WIDTH:0]    result,
    output logic              parity,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int RW = WIDTH + 1;
    localparam int DW = 4 * DIGITS;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [1:0]        r_sel;
    logic [RW-1:0]     r_result;
    logic              r_neg;
    logic              r_parity;
    logic [PW-1:0]     r_presc;
    logic [IW-1:0]     r_idx;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;
    logic              r_dp;

    logic              w_capture;
    logic [RW-1:0]     w_sum;
    logic [RW-1:0]     w_diff;
    logic              w_par;
    logic [RW-1:0]     w_cmp;
    logic [RW-1:0]     w_calc;
    logic [RW-1:0]     w_res_next;
    logic              w_neg_next;
    logic [RW-1:0]     w_mag;
    logic [DW-1:0]     w_disp;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [PW-1:0]     w_presc_next;
    logic [IW-1:0]     w_idx_next;
    logic [DIGITS-1:0] w_an_next;
    logic [6:0]        w_seg_next;
    logic              w_dp_next;

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0: hex_font = 7'b0000001;
            4'h1: hex_font = 7'b1001111;
            4'h2: hex_font = 7'b0010010;
            4'h3: hex_font = 7'b0000110;
            4'h4: hex_font = 7'b1001100;
            4'h5: hex_font = 7'b0100100;
            4'h6: hex_font = 7'b0100000;
            4'h7: hex_font = 7'b0001111;
            4'h8: hex_font = 7'b0000000;
            4'h9: hex_font = 7'b0000100;
            4'hA: hex_font = 7'b0001000;
            4'hB: hex_font = 7'b1100000;
            4'hC: hex_font = 7'b0110001;
            4'hD: hex_font = 7'b1000010;
            4'hE: hex_font = 7'b0110000;
            default: hex_font = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (load) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_SHOW;
            S_SHOW:  if (load) w_state_next = S_EXEC;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_capture = load && ((r_state == S_IDLE) || (r_state == S_SHOW));

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    assign w_par  = ^{r_a, r_b};

    always_comb begin
        w_cmp = RW'(4);
        if (r_a > r_b)
            w_cmp = RW'(1);
        else if (r_a == r_b)
            w_cmp = RW'(2);
    end

    always_comb begin
        case (r_sel)
            2'b00:   w_calc = w_sum;
            2'b01:   w_calc = w_diff;
            2'b10:   w_calc = {{WIDTH{1'b0}}, w_par};
            default: w_calc = w_cmp;
        endcase
    end

    // Display path looks at next-cycle result so an/seg/dp change together with result.
    assign w_res_next = (r_state == S_EXEC) ? w_calc : r_result;
    assign w_neg_next = (r_state == S_EXEC) ? ((r_sel == 2'b01) && w_calc[WIDTH]) : r_neg;
    assign w_mag      = w_neg_next ? (RW'(0) - w_res_next) : w_res_next;
    assign w_disp     = DW'(w_mag);

    always_comb begin
        w_presc_next = r_presc;
        w_idx_next   = r_idx;
        if (r_state == S_SHOW) begin
            if (r_presc == PW'(REFRESH_DIV - 1)) begin
                w_presc_next = '0;
                w_idx_next   = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                w_presc_next = r_presc + 1'b1;
            end
        end
    end

    assign w_nib = w_disp[{w_idx_next, 2'b00} +: 4];

`ifdef LEAD_ZERO_BLANK_EN
    logic [DW-1:0] w_shift;
    assign w_shift = w_disp >> {w_idx_next, 2'b00};
    assign w_blank = (w_idx_next != '0) && (w_shift == '0);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_an_next  = '1;
        w_seg_next = 7'h7F;
        w_dp_next  = 1'b1;
        if (w_state_next == S_SHOW) begin
            w_an_next  = ~(DIGITS'(1) << w_idx_next);
            w_seg_next = w_blank ? 7'h7F : hex_font(w_nib);
            w_dp_next  = !(w_neg_next && (w_idx_next == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_parity <= 1'b0;
            r_presc  <= '0;
            r_idx    <= '0;
            r_an     <= '1;
            r_seg    <= 7'h7F;
            r_dp     <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_a   <= in_a;
                r_b   <= in_b;
                r_sel <= sel;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_calc;
                r_parity <= w_par;
            end
            r_neg   <= w_neg_next;
            r_presc <= w_presc_next;
            r_idx   <= w_idx_next;
            r_an    <= w_an_next;
            r_seg   <= w_seg_next;
            r_dp    <= w_dp_next;
        end
    end

    assign busy         = (r_state == S_EXEC);
    assign result_valid = (r_state == S_SHOW);
    assign result       = r_result;
    assign parity       = r_parity;
    assign an           = r_an;
    assign seg          = r_seg;
    assign dp           = r_dp;

endmodule

// File: tb/tb_alu_seg_scan.sv
// tb/tb_alu_seg_scan.sv - self-checking bench for alu_seg_scan (WIDTH=3, DIGITS=2, REFRESH_DIV=4).
module tb_alu_seg_scan;

    localparam int RDIV = 4;
`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] SEG1_ZERO = LZB ? 7'h7F : 7'b0000001;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic [1:0] sel;
    logic       load;
    logic       busy;
    logic       result_valid;
    logic [3:0] result;
    logic       parity;
    logic [1:0] an;
    logic [6:0] seg;
    logic       dp;

    alu_seg_scan #(.WIDTH(3), .DIGITS(2), .REFRESH_DIV(RDIV)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .sel(sel), .load(load),
        .busy(busy), .result_valid(result_valid), .result(result), .parity(parity),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] s;
        logic [3:0] res;
        logic       par;
        logic [6:0] seg0;
        logic       dp0;
        logic [6:0] seg1;
    } vec_t;

    vec_t       vt [10];
    logic [6:0] font [16];
    int         n_checks = 0;
    int         n_fail = 0;
    int         show_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE/SHOW: load, EXEC, then ncyc SHOW cycles checked against scan model.
    task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s,
                          input logic [3:0] er, input logic ep, input logic [6:0] s0,
                          input logic d0, input logic [6:0] s1, input int ncyc, input bit hold);
        int d;
        in_a = a; in_b = b; sel = s; load = 1'b1;
        step();
        if (hold) begin
            in_a = ~a; in_b = ~b; sel = s ^ 2'b01;
        end else begin
            load = 1'b0;
        end
        chk("exec_busy", busy, 1'b1);
        chk("exec_valid", result_valid, 1'b0);
        chk("exec_an", an, 2'b11);
        chk("exec_seg", seg, 7'h7F);
        step();
        load = 1'b0;
        chk("result", result, er);
        chk("parity", parity, ep);
        chk("show_valid", result_valid, 1'b1);
        for (int i = 0; i < ncyc; i++) begin
            d = (show_n / RDIV) % 2;
            chk("show_busy", busy, 1'b0);
            chk("scan_an", an, (d == 0) ? 2'b10 : 2'b01);
            chk("scan_seg", seg, (d == 0) ? s0 : s1);
            chk("scan_dp", dp, (d == 0) ? d0 : 1'b1);
            show_n++;
            if (i < ncyc - 1) step();
        end
    endtask

    task automatic run_model(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s,
                             input int ncyc);
        int r, v, p;
        bit neg;
        logic [6:0] s1;
        case (s)
            2'b00: r = (a + b) & 15;
            2'b01: r = (int'(a) - int'(b)) & 15;
            2'b10: r = ($countones(a) + $countones(b)) % 2;
            default: r = (a > b) ? 1 : ((a == b) ? 2 : 4);
        endcase
        p   = ($countones(a) + $countones(b)) % 2;
        neg = (s == 2'b01) && (a < b);
        v   = neg ? (int'(b) - int'(a)) : r;
        s1  = (LZB && ((v >> 4) == 0)) ? 7'h7F : font[(v >> 4) & 15];
        run_op(a, b, s, 4'(r), p[0], font[v & 15], !neg, s1, ncyc, 1'b0);
    endtask

    initial begin
        font = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        vt[0] = '{3'd5, 3'd6, 2'b00, 4'hB, 1'b0, 7'b1100000, 1'b1, SEG1_ZERO};
        vt[1] = '{3'd2, 3'd5, 2'b01, 4'hD, 1'b1, 7'b0000110, 1'b0, SEG1_ZERO};
        vt[2] = '{3'd7, 3'd7, 2'b11, 4'h2, 1'b0, 7'b0010010, 1'b1, SEG1_ZERO};
        vt[3] = '{3'd7, 3'd1, 2'b11, 4'h1, 1'b0, 7'b1001111, 1'b1, SEG1_ZERO};
        vt[4] = '{3'd1, 3'd7, 2'b11, 4'h4, 1'b0, 7'b1001100, 1'b1, SEG1_ZERO};
        vt[5] = '{3'd7, 3'd7, 2'b00, 4'hE, 1'b0, 7'b0110000, 1'b1, SEG1_ZERO};
        vt[6] = '{3'd3, 3'd1, 2'b10, 4'h1, 1'b1, 7'b1001111, 1'b1, SEG1_ZERO};
        vt[7] = '{3'd0, 3'd0, 2'b01, 4'h0, 1'b0, 7'b0000001, 1'b1, SEG1_ZERO};
        vt[8] = '{3'd0, 3'd7, 2'b01, 4'h9, 1'b1, 7'b0001111, 1'b0, SEG1_ZERO};
        vt[9] = '{3'd1, 3'd2, 2'b00, 4'h3, 1'b0, 7'b0000110, 1'b1, SEG1_ZERO};

        rst = 1'b1; load = 1'b0; in_a = 3'd0; in_b = 3'd0; sel = 2'b00;
        step();
        step();
        chk("rst_an", an, 2'b11);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_result", result, 4'h0);
        chk("rst_parity", parity, 1'b0);
        rst = 1'b0;
        step();
        chk("idle_an", an, 2'b11);
        chk("idle_valid", result_valid, 1'b0);

        for (int i = 0; i < 10; i++)
            run_op(vt[i].a, vt[i].b, vt[i].s, vt[i].res, vt[i].par,
                   vt[i].seg0, vt[i].dp0, vt[i].seg1, 3 + (i % 7), 1'b0);

        // Full scan cycle plus load held across EXEC with changed operands.
        run_op(3'd5, 3'd6, 2'b00, 4'hB, 1'b0, 7'b1100000, 1'b1, SEG1_ZERO, 12, 1'b1);

        // Reset in mid-SHOW blanks on the next edge and restarts the scan at digit 0.
        rst = 1'b1;
        step();
        chk("midrst_an", an, 2'b11);
        chk("midrst_seg", seg, 7'h7F);
        chk("midrst_dp", dp, 1'b1);
        chk("midrst_valid", result_valid, 1'b0);
        chk("midrst_result", result, 4'h0);
        rst = 1'b0;
        show_n = 0;
        step();
        run_op(3'd2, 3'd5, 2'b01, 4'hD, 1'b1, 7'b0000110, 1'b0, SEG1_ZERO, 6, 1'b0);

        for (int i = 0; i < 25; i++)
            run_model(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      2'($urandom_range(0, 3)), int'($urandom_range(1, 9)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
